// File: rtl/oht2bin_pkg.sv
// Shared definitions for the one-hot to binary encoder.
package oht2bin_pkg;

  // Selects how each combinational encoder is built; both give identical results.
  typedef enum logic [0:0] {
    IMP_BIT_TABLE = 1'b0,
    IMP_LOOP      = 1'b1
  } imp_e;

  // True when v is a non-zero power of two.
  function automatic bit isPow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/oht2bin_base.sv
// Combinational one-hot encoder: binary index (OR of indices when multi-hot) and any-bit-set flag.
// With WIDTH == 1 the index has no meaningful bits; a single zero bit is kept so the port exists.
module oht2bin_base
  import oht2bin_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG     = $clog2(WIDTH),
  localparam int BIN_W         = (WIDTH_LOG > 0) ? WIDTH_LOG : 1
) (
  input  logic [WIDTH-1:0] oht,
  output logic [BIN_W-1:0] bin,
  output logic             vld
);

  assign vld = |oht;

  if (IMPLEMENTATION == int'(IMP_BIT_TABLE)) begin : gBitTable
    // Each index bit k is the OR of every input whose position has bit k set.
    always_comb begin
      bin = '0;
      for (int k = 0; k < WIDTH_LOG; k++) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (i[k]) bin[k] = bin[k] | oht[i];
        end
      end
    end
  end else if (IMPLEMENTATION == int'(IMP_LOOP)) begin : gLoop
    // Accumulate the index of every set input into the result.
    always_comb begin
      bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (oht[i]) bin = bin | BIN_W'(i);
      end
    end
  end else begin : gBadImpl
    $error("oht2bin_base: IMPLEMENTATION must be 0 (bit table) or 1 (loop)");
  end

endmodule

// File: rtl/oht2bin.sv
// Registered one-hot to binary encoder built from SPLIT segment encoders plus a
// segment-valid encoder that supplies the upper index bits.
module oht2bin
  import oht2bin_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int SPLIT          = 4,
  parameter int IMPLEMENTATION = 0,
  localparam int WIDTH_LOG     = $clog2(WIDTH),
  localparam int SPLIT_LOG     = $clog2(SPLIT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     oht,
  output logic [WIDTH_LOG-1:0] bin,
  output logic                 vld
);

  localparam int SEG_W   = WIDTH / SPLIT;
  localparam int SEG_LOG = WIDTH_LOG - SPLIT_LOG;
  localparam int SEG_BW  = (SEG_LOG > 0) ? SEG_LOG : 1;
  localparam int UP_BW   = (SPLIT_LOG > 0) ? SPLIT_LOG : 1;

  if (!isPow2(WIDTH) || WIDTH < 2) begin : gBadWidth
    $error("oht2bin: WIDTH must be a power of two and at least 2");
  end
  if (!isPow2(SPLIT) || SPLIT > WIDTH) begin : gBadSplit
    $error("oht2bin: SPLIT must be a power of two between 1 and WIDTH");
  end

  logic [SEG_BW-1:0]    segBin [SPLIT];
  logic [SPLIT-1:0]     segVld;
  logic [UP_BW-1:0]     upperBin;
  logic                 anyVld;
  logic [SEG_BW-1:0]    lowOr;
  logic [WIDTH_LOG-1:0] bin_d;
  logic [WIDTH_LOG-1:0] bin_q;
  logic                 vld_q;

  for (genvar s = 0; s < SPLIT; s++) begin : gSeg
    oht2bin_base #(
      .WIDTH          (SEG_W),
      .IMPLEMENTATION (IMPLEMENTATION)
    ) uSeg (
      .oht (oht[s*SEG_W +: SEG_W]),
      .bin (segBin[s]),
      .vld (segVld[s])
    );
  end

  oht2bin_base #(
    .WIDTH          (SPLIT),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) uUpper (
    .oht (segVld),
    .bin (upperBin),
    .vld (anyVld)
  );

  // Combine the in-segment indices of every segment that has a bit set.
  always_comb begin
    lowOr = '0;
    for (int s = 0; s < SPLIT; s++) begin
      if (segVld[s]) lowOr = lowOr | segBin[s];
    end
  end

  if (SEG_LOG == 0) begin : gAllUpper
    assign bin_d = upperBin[WIDTH_LOG-1:0];
  end else if (SPLIT_LOG == 0) begin : gAllLower
    assign bin_d = lowOr[WIDTH_LOG-1:0];
  end else begin : gBoth
    assign bin_d = {upperBin[SPLIT_LOG-1:0], lowOr[SEG_LOG-1:0]};
  end

  // Output register: one cycle of latency, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      vld_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      vld_q <= anyVld;
    end
  end

  assign bin = bin_q;
  assign vld = vld_q;

endmodule

// File: tb/tb_oht2bin.sv
// Scoreboard bench for oht2bin: six instances (SPLIT 1/4/16 x both implementations)
// share one stimulus stream and are checked against a reference model.
module tb_oht2bin;

  localparam int N = 6;

  typedef struct packed {
    logic [3:0] bin;
    logic       vld;
  } expect_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] oht;
  logic [3:0]  binOut [N];
  logic        vldOut [N];

  int      errors = 0;
  int      checks = 0;
  expect_t sbQueue[$];

  for (genvar g = 0; g < N; g++) begin : gDut
    localparam int SP = (g / 2 == 0) ? 1 : ((g / 2 == 1) ? 4 : 16);
    oht2bin #(
      .WIDTH          (16),
      .SPLIT          (SP),
      .IMPLEMENTATION (g % 2)
    ) uDut (
      .clk   (clk),
      .rst_n (rst_n),
      .oht   (oht),
      .bin   (binOut[g]),
      .vld   (vldOut[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: index is the OR of the positions of all set bits; valid if any set.
  function automatic expect_t model(input logic [15:0] v);
    expect_t e;
    e.bin = 4'd0;
    e.vld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) begin
        e.bin = e.bin | 4'(i);
        e.vld = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int inst, input logic [3:0] act,
                             input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst=%0d got=%0d want=%0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic checkAllZero(input string name);
    for (int g = 0; g < N; g++) begin
      checkOutput({name, "_bin"}, g, binOut[g], 4'd0);
      checkOutput({name, "_vld"}, g, {3'd0, vldOut[g]}, 4'd0);
    end
  endtask

  // Drive one input on the falling edge and queue its expected registered result.
  task automatic applyStimulus(input logic [15:0] v);
    @(negedge clk);
    oht = v;
    sbQueue.push_back(model(v));
  endtask

  task automatic drainQueue();
    int budget;
    budget = 20;
    while (sbQueue.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (sbQueue.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d want=0", sbQueue.size());
      sbQueue.delete();
    end
  endtask

  // Monitor: after each rising edge, pop one expectation and compare every instance.
  always @(posedge clk) begin
    expect_t e;
    #1;
    if (rst_n && sbQueue.size() != 0) begin
      e = sbQueue.pop_front();
      for (int g = 0; g < N; g++) begin
        checkOutput("bin", g, binOut[g], e.bin);
        checkOutput("vld", g, {3'd0, vldOut[g]}, {3'd0, e.vld});
      end
    end
  end

  initial begin
    logic [15:0] r;
    rst_n = 1'b0;
    oht   = 16'h0100;
    #2;
    checkAllZero("reset_noclk");
    @(posedge clk); #1;
    checkAllZero("reset_clk");

    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(16'h0000);
    for (int i = 0; i < 16; i++) applyStimulus(16'(1) << i);
    applyStimulus(16'h0006);
    applyStimulus(16'h0110);
    applyStimulus(16'h0001);
    applyStimulus(16'h0000);
    applyStimulus(16'h0400);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       r = 16'h0000;
        1:       r = 16'(1) << $urandom_range(0, 15);
        default: r = 16'($urandom);
      endcase
      applyStimulus(r);
    end
    for (int i = 0; i < 16; i++) applyStimulus(16'(1) << (15 - i));
    drainQueue();

    // Mid-stream reset: outputs hold a non-zero result, then clear at once.
    @(negedge clk);
    oht = 16'h8000;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("reset_async");
    oht = 16'h0400;
    @(posedge clk); #1;
    checkAllZero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    oht   = 16'h0000;
    applyStimulus(16'h0020);
    applyStimulus(16'h0000);
    drainQueue();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
